cart_loader: RTL

- Sits between the hps_io ioctl download stream and the po8 CoCo2 core.
- Captures a CCC cartridge image, up to 16 KiB, into on-chip dual-port RAM.
- Serves CPU reads of the $C000-$FEFF cartridge window with power-of-two mirroring.
- Drives the CART autostart line once a valid image is resident.

---
 rtl/cart_pkg.sv | 32 +++
 rtl/cart_rom_dp.sv | 27 ++
 rtl/cart_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the CoCo2 cartridge loader.
package cart_pkg;

  localparam int CART_ADDR_W = 14;
  localparam int CART_BYTES  = 16384;

  localparam logic [CART_ADDR_W-1:0] MASK_2K  = 14'h07FF;
  localparam logic [CART_ADDR_W-1:0] MASK_4K  = 14'h0FFF;
  localparam logic [CART_ADDR_W-1:0] MASK_8K  = 14'h1FFF;
  localparam logic [CART_ADDR_W-1:0] MASK_16K = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINAL,
    READY
  } cart_state_t;

  // Smallest power-of-two window (2K minimum) that covers the image.
  function automatic logic [CART_ADDR_W-1:0] mirror_mask(input logic [CART_ADDR_W:0] size);
    if (int'(size) <= CART_BYTES / 8) begin
      return MASK_2K;
    end else if (int'(size) <= CART_BYTES / 4) begin
      return MASK_4K;
    end else if (int'(size) <= CART_BYTES / 2) begin
      return MASK_8K;
    end else begin
      return MASK_16K;
    end
  endfunction

endpackage

// File: rtl/cart_rom_dp.sv
// Simple dual-port cartridge RAM: port A write-only (loader), port B
// registered read with enable (CPU).
module cart_rom_dp #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/cart_loader.sv
// Captures a CCC cartridge image from the ioctl stream and serves the $C000
// window with mirroring. Optional CART_CHECKSUM_EN adds a 16-bit byte sum output.
module cart_loader
  import cart_pkg::*;
#(
  parameter int         ADDR_W     = CART_ADDR_W,
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int         CART_HALF  = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cart_present,
  output logic              cart_n,
  input  logic              autostart_en,
  output logic              overflow,
  output logic [ADDR_W:0]   img_size
`ifdef CART_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int CNT_W = (CART_HALF > 1) ? $clog2(CART_HALF) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CART_HALF - 1);

  cart_state_t       state_q;
  logic              download_q;
  logic [ADDR_W:0]   max_addr_q;
  logic [ADDR_W-1:0] mask_q;
  logic [CNT_W-1:0]  half_cnt_q;
  logic              cart_present_q;
  logic              cart_n_q;
  logic              overflow_q;
  logic [ADDR_W:0]   img_size_q;
  logic              rd_sel_q;
  logic [7:0]        ram_rdata;

  logic              index_hit;
  logic              dl_rise;
  logic              dl_fall;
  logic              load_start;
  logic              addr_in_range;
  logic              wr_accept;
  logic              ram_we;
  logic [ADDR_W:0]   wr_end;

  assign index_hit     = (ioctl_index == CART_INDEX);
  assign dl_rise       = ioctl_download & ~download_q;
  assign dl_fall       = ~ioctl_download & download_q;
  assign load_start    = (state_q == IDLE || state_q == READY) && dl_rise && index_hit;
  assign addr_in_range = (ioctl_addr[15:ADDR_W] == '0);
  assign wr_accept     = (state_q == LOAD) && ioctl_wr && index_hit;
  assign ram_we        = wr_accept && addr_in_range;
  // In-range addresses top out at 2^ADDR_W-1, so the +1 end pointer saturates at 2^ADDR_W.
  assign wr_end        = {1'b0, ioctl_addr[ADDR_W-1:0]} + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= IDLE;
      // Seed the edge detector with the live level so an interrupted download is not re-entered.
      download_q     <= ioctl_download;
      max_addr_q     <= '0;
      mask_q         <= MASK_2K;
      half_cnt_q     <= '0;
      cart_present_q <= 1'b0;
      cart_n_q       <= 1'b1;
      overflow_q     <= 1'b0;
      img_size_q     <= '0;
    end else begin
      download_q <= ioctl_download;
      case (state_q)
        IDLE, READY: begin
          if (load_start) begin
            state_q        <= LOAD;
            cart_present_q <= 1'b0;
            overflow_q     <= 1'b0;
            img_size_q     <= '0;
            max_addr_q     <= '0;
            cart_n_q       <= 1'b1;
            half_cnt_q     <= '0;
          end else if (state_q == READY) begin
            if (!autostart_en) begin
              half_cnt_q <= '0;
              cart_n_q   <= 1'b1;
            end else if (half_cnt_q == HALF_LAST) begin
              half_cnt_q <= '0;
              cart_n_q   <= ~cart_n_q;
            end else begin
              half_cnt_q <= half_cnt_q + 1'b1;
            end
          end
        end
        LOAD: begin
          if (ram_we && (wr_end > max_addr_q)) begin
            max_addr_q <= wr_end;
          end
          if (wr_accept && !addr_in_range) begin
            overflow_q <= 1'b1;
          end
          if (dl_fall) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          img_size_q <= max_addr_q;
          mask_q     <= mirror_mask(max_addr_q);
          half_cnt_q <= '0;
          cart_n_q   <= 1'b1;
          if (max_addr_q == '0) begin
            state_q <= IDLE;
          end else begin
            state_q        <= READY;
            cart_present_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The data register and its source select both update only on cpu_rd, so cpu_dout holds between reads.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_sel_q <= 1'b0;
    end else if (cpu_rd) begin
      rd_sel_q <= cart_present_q;
    end
  end

  cart_rom_dp #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk       (clk_sys),
    .wr_en_i   (ram_we),
    .wr_addr_i (ioctl_addr[ADDR_W-1:0]),
    .wr_data_i (ioctl_data),
    .rd_en_i   (cpu_rd),
    .rd_addr_i (cpu_addr & mask_q),
    .rd_data_o (ram_rdata)
  );

  assign cpu_dout     = rd_sel_q ? ram_rdata : 8'hFF;
  assign cart_present = cart_present_q;
  assign cart_n       = cart_n_q;
  assign overflow     = overflow_q;
  assign img_size     = img_size_q;

`ifdef CART_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (load_start) begin
      checksum_q <= '0;
    end else if (ram_we) begin
      checksum_q <= checksum_q + {8'h00, ioctl_data};
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
